// File: rtl/clk_phase_pkg.sv
// Shared types and defaults for the clock-phase generator.
package clk_phase_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STEP     = 2'd2,
        STOPPING = 2'd3
    } state_e;

    localparam int CNT_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 0;
endpackage

// File: rtl/clk_phase_gen.sv
// Programmable divided reference with rise/fall strobes, free-running or single-step.
module clk_phase_gen
    import clk_phase_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
    output logic             clk_div_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             busy_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic at_end;
    logic boundary;
    logic done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            half_q       <= CNT_W'(DEFAULT_DIV);
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            clk_q        <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            clk_q        <= clk_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        half_d       = half_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        clk_d        = clk_q;
        rise_d       = 1'b0;
        fall_d       = 1'b0;
        done         = 1'b0;
        at_end       = (cnt_q == half_q);
        // low->high toggle: the only point where a pending divisor may take effect
        boundary     = at_end && !clk_q;

        if (state_q == IDLE) begin
            if (load_i)
                half_d = div_i;
            if (en_i || step_i) begin
                state_d = en_i ? RUN : STEP;
                clk_d   = 1'b1;
                rise_d  = 1'b1;
                cnt_d   = '0;
            end
        end else begin
            if (at_end) begin
                clk_d  = ~clk_q;
                cnt_d  = '0;
                rise_d = ~clk_q;
                fall_d = clk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            if (boundary && pend_valid_q) begin
                half_d       = pend_q;
                pend_valid_d = 1'b0;
            end
            // a load on the boundary itself re-arms pending for the next one
            if (load_i) begin
                pend_d       = div_i;
                pend_valid_d = 1'b1;
            end

            if (state_q == RUN) begin
                if (!en_i)
                    state_d = STOPPING;
            end else if (state_q == STOPPING) begin
                if (en_i)
                    state_d = RUN;
                else if (boundary)
                    done = 1'b1;
            end else begin
                if (boundary)
                    done = 1'b1;
            end

            // finishing the low phase: park low, flush any pending divisor now
            if (done) begin
                state_d      = IDLE;
                clk_d        = 1'b0;
                rise_d       = 1'b0;
                cnt_d        = '0;
                half_d       = load_i ? div_i : (pend_valid_q ? pend_q : half_q);
                pend_valid_d = 1'b0;
            end
        end
    end

    assign clk_div_o = clk_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_clk_phase_gen.sv
// Vector/scoreboard bench for clk_phase_gen: expected {clk_div,rise,fall,busy} queued per drive.
module tb_clk_phase_gen;

    localparam int W = 16;

    typedef struct {
        logic         en;
        logic         step;
        logic         load;
        logic [W-1:0] div;
        logic [3:0]   exp;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        int         id;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         step;
    logic         load;
    logic [W-1:0] div;
    logic         clk_div;
    logic         rise;
    logic         fall;
    logic         busy;

    int   checks   = 0;
    int   failures = 0;
    int   vec_id   = 0;
    exp_t exp_q[$];
    vec_t tbl[17];

    clk_phase_gen #(.CNT_W(W), .DEFAULT_DIV(2)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .en_i     (en),
        .step_i   (step),
        .load_i   (load),
        .div_i    (div),
        .clk_div_o(clk_div),
        .rise_o   (rise),
        .fall_o   (fall),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic e, logic s, logic l, logic [W-1:0] d,
                                logic c, logic r, logic f, logic b);
        vec_t v;
        v.en = e; v.step = s; v.load = l; v.div = d;
        v.exp = {c, r, f, b};
        return v;
    endfunction

    task automatic step_v(input vec_t v);
        exp_t e;
        @(negedge clk);
        en = v.en; step = v.step; load = v.load; div = v.div;
        e.exp = v.exp;
        e.id  = vec_id;
        vec_id++;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [3:0] exp);
        checks++;
        if ({clk_div, rise, fall, busy} !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, {clk_div, rise, fall, busy}, exp);
        end
    endtask

    // Scoreboard: one expected record per clock edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({clk_div, rise, fall, busy} !== e.exp) begin
                failures++;
                $display("FAIL vec%0d outs{clk,rise,fall,busy} got=%b want=%b",
                         e.id, {clk_div, rise, fall, busy}, e.exp);
            end
            checks++;
            if (rise && fall) begin
                failures++;
                $display("FAIL vec%0d strobes got=both-high want=exclusive", e.id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; step = 1'b0; load = 1'b0; div = '0;
        #2;
        check_now("reset_state", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // div=1 run, switch to div=0 while running, then stop
        tbl[0]  = mk(0,0,1,1, 0,0,0,0);
        tbl[1]  = mk(1,0,0,0, 1,1,0,1);
        tbl[2]  = mk(1,0,0,0, 1,0,0,1);
        tbl[3]  = mk(1,0,0,0, 0,0,1,1);
        tbl[4]  = mk(1,0,0,0, 0,0,0,1);
        tbl[5]  = mk(1,0,0,0, 1,1,0,1);
        tbl[6]  = mk(1,0,1,0, 1,0,0,1);
        tbl[7]  = mk(1,0,0,0, 0,0,1,1);
        tbl[8]  = mk(1,0,0,0, 0,0,0,1);
        tbl[9]  = mk(1,0,0,0, 1,1,0,1);
        tbl[10] = mk(1,0,0,0, 0,0,1,1);
        tbl[11] = mk(1,0,0,0, 1,1,0,1);
        tbl[12] = mk(1,0,0,0, 0,0,1,1);
        tbl[13] = mk(1,0,0,0, 1,1,0,1);
        tbl[14] = mk(0,0,0,0, 0,0,1,1);
        tbl[15] = mk(0,0,0,0, 0,0,0,0);
        tbl[16] = mk(0,0,0,0, 0,0,0,0);
        for (int i = 0; i < 17; i++) step_v(tbl[i]);

        // div=3, en dropped during 2nd high cycle: 4 high, 4 low, idle
        step_v(mk(0,0,1,3, 0,0,0,0));
        step_v(mk(1,0,0,0, 1,1,0,1));
        for (int i = 0; i < 3; i++) step_v(mk(0,0,0,0, 1,0,0,1));
        step_v(mk(0,0,0,0, 0,0,1,1));
        for (int i = 0; i < 3; i++) step_v(mk(0,0,0,0, 0,0,0,1));
        for (int i = 0; i < 2; i++) step_v(mk(0,0,0,0, 0,0,0,0));

        // en reasserted during STOPPING: period continues unbroken
        step_v(mk(1,0,0,0, 1,1,0,1));
        step_v(mk(0,0,0,0, 1,0,0,1));
        step_v(mk(0,0,0,0, 1,0,0,1));
        step_v(mk(1,0,0,0, 1,0,0,1));
        step_v(mk(1,0,0,0, 0,0,1,1));
        for (int i = 0; i < 3; i++) step_v(mk(1,0,0,0, 0,0,0,1));
        step_v(mk(1,0,0,0, 1,1,0,1));
        for (int i = 0; i < 3; i++) step_v(mk(0,0,0,0, 1,0,0,1));
        step_v(mk(0,0,0,0, 0,0,1,1));
        for (int i = 0; i < 3; i++) step_v(mk(0,0,0,0, 0,0,0,1));
        step_v(mk(0,0,0,0, 0,0,0,0));

        // single step, div=2, with a second step request ignored
        step_v(mk(0,0,1,2, 0,0,0,0));
        step_v(mk(0,1,0,0, 1,1,0,1));
        step_v(mk(0,1,0,0, 1,0,0,1));
        step_v(mk(0,0,0,0, 1,0,0,1));
        step_v(mk(0,0,0,0, 0,0,1,1));
        step_v(mk(0,0,0,0, 0,0,0,1));
        step_v(mk(0,0,0,0, 0,0,0,1));
        for (int i = 0; i < 3; i++) step_v(mk(0,0,0,0, 0,0,0,0));

        // pending load: div 1 -> 4 mid-high, applied at next rise
        step_v(mk(0,0,1,1, 0,0,0,0));
        step_v(mk(1,0,0,0, 1,1,0,1));
        step_v(mk(1,0,1,4, 1,0,0,1));
        step_v(mk(1,0,0,0, 0,0,1,1));
        step_v(mk(1,0,0,0, 0,0,0,1));
        step_v(mk(1,0,0,0, 1,1,0,1));
        for (int i = 0; i < 4; i++) step_v(mk(1,0,0,0, 1,0,0,1));
        step_v(mk(1,0,0,0, 0,0,1,1));
        for (int i = 0; i < 4; i++) step_v(mk(1,0,0,0, 0,0,0,1));
        step_v(mk(1,0,0,0, 1,1,0,1));
        for (int i = 0; i < 4; i++) step_v(mk(0,0,0,0, 1,0,0,1));
        step_v(mk(0,0,0,0, 0,0,1,1));
        for (int i = 0; i < 4; i++) step_v(mk(0,0,0,0, 0,0,0,1));
        step_v(mk(0,0,0,0, 0,0,0,0));

        // async reset mid-RUN with div=1, then default half period (3 cycles)
        step_v(mk(0,0,1,1, 0,0,0,0));
        step_v(mk(1,0,0,0, 1,1,0,1));
        step_v(mk(1,0,0,0, 1,0,0,1));
        step_v(mk(1,0,0,0, 0,0,1,1));
        @(negedge clk);
        en = 1'b0; load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_mid_run", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        step_v(mk(1,0,0,0, 1,1,0,1));
        step_v(mk(1,0,0,0, 1,0,0,1));
        step_v(mk(1,0,0,0, 1,0,0,1));
        step_v(mk(1,0,0,0, 0,0,1,1));
        step_v(mk(0,0,0,0, 0,0,0,1));
        step_v(mk(0,0,0,0, 0,0,0,1));
        step_v(mk(0,0,0,0, 0,0,0,0));

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_phase_gen.md
Name: clk_phase_gen

Overview:
- Programmable clock-phase generator for the CPU core.
- Produces a divided, glitch-free, 50%-duty reference `clk_div_o` plus one-cycle `rise_o`/`fall_o` strobes. Logic that must act on "the other edge" then uses these as clock enables in the `clk_i` domain instead of a second clock.
- Supports free-running and single-step (one period) modes. Used for debug stepping and slow peripheral timing.

Parameters:
- CNT_W, 16, width of the half-period divisor and internal counter.
- DEFAULT_DIV, 0, half-period divisor loaded at reset. Half period = DEFAULT_DIV+1 cycles.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- en_i  input  1  level; run continuously while high.
- step_i  input  1  pulse; generate exactly one full period (only honoured in IDLE).
- load_i  input  1  pulse; capture `div_i` as the new half-period divisor.
- div_i  input  CNT_W  half-period divisor: high and low phases each last `div_i`+1 cycles.
- clk_div_o  output  1  divided reference, registered.
- rise_o  output  1  high in the first cycle of each high phase of `clk_div_o`.
- fall_o  output  1  high in the first cycle of each low phase of `clk_div_o`.
- busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (`rst_ni`=0, asynchronous): state=IDLE, `clk_div_o`=0, `rise_o`=0, `fall_o`=0, `busy_o`=0, cnt=0, half_q=DEFAULT_DIV, pend_valid=0.
- All outputs are registered; `busy_o` is derived from the state register.
- States: IDLE, RUN, STEP, STOPPING.
- Counting rule in RUN/STEP/STOPPING:
  - if cnt==half_q: toggle `clk_div_o`, cnt←0;
  - else cnt←cnt+1.
  - Each phase therefore lasts exactly half_q+1 cycles.
- Strobes: `rise_o`=1 in the cycle `clk_div_o` first reads 1; `fall_o`=1 in the cycle it first reads 0 after a high phase. Never both high in one cycle.
- IDLE:
  - `en_i`=1 → RUN.
  - `en_i`=0 and `step_i`=1 → STEP.
  - Both high → RUN (en wins).
  - On either transition, the next cycle has `clk_div_o`=1, `rise_o`=1, cnt=0.
  - Latency: 1 cycle from the sampled request to the first high cycle.
- RUN: free-running toggle. `en_i`=0 sampled → STOPPING; the current phase is not truncated.
- STOPPING:
  - Continues counting; completes any remaining high phase and a full low phase.
  - At cnt==half_q with `clk_div_o`=0 → IDLE, `clk_div_o` stays 0, no `rise_o`.
  - `en_i`=1 sampled in STOPPING → RUN with no disturbance to count or phase.
- STEP: one high phase plus one low phase, then → IDLE, same end condition as STOPPING. `en_i` and `step_i` are ignored until IDLE is reached.
- `step_i` in RUN/STEP/STOPPING: ignored, not queued.
- Divisor load:
  - In IDLE, `load_i` writes half_q←`div_i` next cycle.
  - In other states, `div_i` is captured into pend_q and pend_valid=1. half_q←pend_q is applied at the next period boundary, i.e. the low→high toggle, coincident with `rise_o`, and pend_valid clears.
  - Repeated loads before the boundary: the last one wins.
  - A load on the same cycle as a boundary is applied at the following boundary.
  - On entry to IDLE with pend_valid=1: apply pend_q immediately.
- `div_i`=0: divide-by-2; `clk_div_o` toggles every cycle. `rise_o`/`fall_o` alternate every cycle.
- `div_i`=all-ones: counter width CNT_W; no overflow, since cnt never exceeds half_q.
- Reset mid-operation: immediate return to reset values; a pending divisor is discarded.

Decomposition:
- Shared package `clk_phase_pkg`: state enum (IDLE, RUN, STEP, STOPPING), CNT_W default, DEFAULT_DIV default.
- Single module; no sub-module. The counter and FSM are small enough to stay flat.

Test Plan:
- Reset then `div_i`=1 via `load_i` in IDLE, `en_i`=1 at cycle 0:
  - cycles 1-2 `clk_div_o`=1 (`rise_o` at 1);
  - cycles 3-4 `clk_div_o`=0 (`fall_o` at 3);
  - `rise_o` again at 5; `busy_o`=1 from cycle 1.
- `div_i`=0, `en_i` held: `clk_div_o` toggles every cycle; `rise_o`/`fall_o` alternate; never both high.
- `div_i`=3, drop `en_i` in the 2nd cycle of a high phase:
  - high phase completes (4 cycles total), then a full 4-cycle low phase;
  - then IDLE, `busy_o`=0, no further `rise_o`.
  - Repeat with `en_i` reasserted during STOPPING → period continues unbroken.
- `step_i` pulse with `div_i`=2: exactly 3 high + 3 low cycles, one `rise_o`, one `fall_o`, then IDLE. A second `step_i` during STEP has no effect.
- RUN with `div_i`=1; `load_i` with `div_i`=4 mid-high-phase:
  - old timing is kept until the next `rise_o`;
  - from that `rise_o`, phases are 5 cycles each.
- Assert `rst_ni`=0 asynchronously mid-RUN, between clock edges: all outputs read 0 immediately; half_q returns to DEFAULT_DIV.
